// File: rtl/audio_pkg.sv
// Shared definitions for the audio feature pipeline.
//   FRAME_LEN / SAMPLE_W : frame geometry shared by the framer and the windowing stage
//   sample_t / frame_t   : one unsigned sample and one frame (index 0 = oldest sample)
//   framer_state_e       : framer FSM states
package audio_pkg;

  localparam int unsigned FRAME_LEN = 64;
  localparam int unsigned SAMPLE_W  = 12;
  localparam int unsigned PTR_W     = $clog2(FRAME_LEN);
  localparam int unsigned CNT_W     = PTR_W + 1;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef sample_t frame_t [0:FRAME_LEN-1];

  typedef enum logic {
    FILL,
    RUN
  } framer_state_e;

endpackage

// File: rtl/audio_framer_if.sv
// Sample-in / frame-out bundle between a sample source and the audio framer.
//   sample_in, sample_valid : streaming samples, no backpressure
//   clr                     : synchronous restart of framing
//   frame_out, frame_ready, frame_idx : emitted frame, one-cycle strobe, frame counter
// master = sample source / frame consumer, slave = framer.
interface audio_framer_if;
  import audio_pkg::*;

  sample_t     sample_in;
  logic        sample_valid;
  logic        clr;
  frame_t      frame_out;
  logic        frame_ready;
  logic [15:0] frame_idx;

  modport master (
    output sample_in, sample_valid, clr,
    input  frame_out, frame_ready, frame_idx
  );

  modport slave (
    input  sample_in, sample_valid, clr,
    output frame_out, frame_ready, frame_idx
  );

endinterface

// File: rtl/frame_ring_buf.sv
// Ring buffer of FRAME_LEN samples with a rotated full-array read.
//   clk, rst     : clock, asynchronous active-high reset (pointer only)
//   clr_i        : synchronous pointer restart
//   we_i/wdata_i : write one sample at wr_ptr, then advance the pointer
//   wr_ptr_o     : current write pointer (= slot of the oldest sample once full)
//   rd_frame_o   : rd_frame_o[k] = mem[(wr_ptr + k) mod FRAME_LEN], oldest first
module frame_ring_buf
  import audio_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             we_i,
  input  sample_t          wdata_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output frame_t           rd_frame_o
);

  sample_t          mem_q [0:FRAME_LEN-1];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
    end else if (we_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Sample storage needs no reset: a frame is only emitted after a full refill.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Index arithmetic is PTR_W bits wide, so the wrap is free.
  always_comb begin
    for (int unsigned k = 0; k < FRAME_LEN; k++) begin
      rd_frame_o[k] = mem_q[wr_ptr_q + PTR_W'(k)];
    end
  end

  assign wr_ptr_o = wr_ptr_q;

endmodule

// File: rtl/audio_framer.sv
// Collects a sample stream into overlapping FRAME_LEN-sample frames.
//   clk, rst : clock, asynchronous active-high reset
//   bus_io   : slave side of audio_framer_if (samples in, frame/strobe/index out)
// HOP new samples separate successive frames; the first frame after reset or clr
// needs FRAME_LEN samples. frame_ready pulses one cycle after the completing sample.
module audio_framer
  import audio_pkg::*;
#(
  parameter int unsigned HOP = 32
) (
  input  logic           clk,
  input  logic           rst,
  audio_framer_if.slave  bus_io
);

  framer_state_e    state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0] hop_cnt_q, hop_cnt_d;
  logic             emit_pending_q, emit_pending_d;
  frame_t           frame_out_q, frame_out_d;
  logic             frame_ready_q, frame_ready_d;
  logic [15:0]      frame_idx_q, frame_idx_d;

  logic             accept;
  logic [PTR_W-1:0] wr_ptr;
  frame_t           rd_frame;

  // A sample presented together with clr is dropped.
  assign accept = bus_io.sample_valid & ~bus_io.clr;

  frame_ring_buf u_ring (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (bus_io.clr),
    .we_i       (accept),
    .wdata_i    (bus_io.sample_in),
    .wr_ptr_o   (wr_ptr),
    .rd_frame_o (rd_frame)
  );

  always_comb begin
    state_d        = state_q;
    fill_cnt_d     = fill_cnt_q;
    hop_cnt_d      = hop_cnt_q;
    emit_pending_d = 1'b0;
    frame_out_d    = frame_out_q;
    frame_ready_d  = emit_pending_q;
    frame_idx_d    = frame_idx_q;

    if (bus_io.clr) begin
      state_d       = FILL;
      fill_cnt_d    = '0;
      hop_cnt_d     = '0;
      frame_ready_d = 1'b0;
      frame_idx_d   = '0;
    end else begin
      // Snapshot uses pre-edge memory, so a sample written on this edge lands in
      // the next frame rather than this one.
      if (emit_pending_q) begin
        frame_out_d = rd_frame;
        frame_idx_d = frame_idx_q + 16'd1;
      end
      if (accept) begin
        unique case (state_q)
          FILL: begin
            if (fill_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
              emit_pending_d = 1'b1;
              state_d        = RUN;
              fill_cnt_d     = '0;
              hop_cnt_d      = '0;
            end else begin
              fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
          end
          RUN: begin
            if (hop_cnt_q == CNT_W'(HOP - 1)) begin
              emit_pending_d = 1'b1;
              hop_cnt_d      = '0;
            end else begin
              hop_cnt_d = hop_cnt_q + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FILL;
      fill_cnt_q     <= '0;
      hop_cnt_q      <= '0;
      emit_pending_q <= 1'b0;
      frame_out_q    <= '{default: '0};
      frame_ready_q  <= 1'b0;
      frame_idx_q    <= '0;
    end else begin
      state_q        <= state_d;
      fill_cnt_q     <= fill_cnt_d;
      hop_cnt_q      <= hop_cnt_d;
      emit_pending_q <= emit_pending_d;
      frame_out_q    <= frame_out_d;
      frame_ready_q  <= frame_ready_d;
      frame_idx_q    <= frame_idx_d;
    end
  end

  // While filling, the ring pointer and the fill count advance in lockstep.
  a_fill_ptr_sync : assert property (@(posedge clk) disable iff (rst)
    (state_q == FILL) |-> (wr_ptr == fill_cnt_q[PTR_W-1:0]));

  assign bus_io.frame_out   = frame_out_q;
  assign bus_io.frame_ready = frame_ready_q;
  assign bus_io.frame_idx   = frame_idx_q;

endmodule
